mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. It serialises accesses onto one request/acknowledge memory port, gives data accesses priority with a bounded-starvation guarantee for fetch, and returns read data and a one-cycle acknowledge to the winning stage. The IF and MEM stages treat the absence of their acknowledge as a stall.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and data access.
// Data has priority; a saturating streak counter forces fetch through after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_elig, dm_elig, fetch_first, grant_if, grant_dm;

  // A requester whose ack is showing is dropping its request, so it must not be re-granted.
  always_comb begin
    if_elig     = if_req && !if_ack_q;
    dm_elig     = dm_req && !dm_ack_q;
    fetch_first = (STARVE_LIMIT != 0) && (streak_q == LIMIT);
    grant_dm    = (state_q == IDLE) && dm_elig && !(if_elig && fetch_first);
    grant_if    = (state_q == IDLE) && if_elig && !grant_dm;
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = DM_BUSY;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            if (streak_q != LIMIT) streak_d = streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (grant_if) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          busy_d     = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      DM_BUSY: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          busy_d     = 1'b0;
          dm_ack_d   = 1'b1;
          dm_rdata_d = mem_we_q ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 (STARVE_LIMIT=4) and instance 1 (STARVE_LIMIT=0) share requester
// stimulus and are both checked every cycle against a rule-level model, plus directed literal checks.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        auto_a, mack_drv;
  logic [31:0] mrd_drv;

  logic [1:0]       if_ack, dm_ack, mem_req, mem_we, busy, mack;
  logic [1:0][31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mrd;

  // Instance 0 memory is scripted or zero-wait; instance 1 memory is always zero-wait.
  assign mack[0] = auto_a ? mem_req[0] : mack_drv;
  assign mrd[0]  = auto_a ? {mem_addr[0][15:0], 16'hA5A5} : mrd_drv;
  assign mack[1] = mem_req[1];
  assign mrd[1]  = {mem_addr[1][15:0], 16'hB00B};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_ack(mack[0]), .mem_rdata(mrd[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) u_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_ack(mack[1]), .mem_rdata(mrd[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- rule-level model (owner: 0 none, 1 fetch, 2 data) ----------------
  localparam int LIM [2] = '{4, 0};
  bit          started = 1'b0;
  int          m_owner  [2];
  int          m_streak [2];
  logic [31:0] m_addr   [2];
  logic [31:0] m_wd     [2];
  logic        m_we     [2];
  logic        m_ifack  [2];
  logic        m_dmack  [2];
  logic [31:0] m_ifrd   [2];
  logic [31:0] m_dmrd   [2];

  function automatic int pick_of(input bit f_ok, input bit d_ok, input int streak, input int lim);
    if (d_ok && f_ok) return (lim != 0 && streak == lim) ? 1 : 2;
    if (d_ok) return 2;
    if (f_ok) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_owner[i] <= 0;  m_streak[i] <= 0;
        m_addr[i]  <= 0;  m_wd[i]     <= 0;  m_we[i] <= 1'b0;
        m_ifack[i] <= 1'b0; m_dmack[i] <= 1'b0;
        m_ifrd[i]  <= 0;  m_dmrd[i]   <= 0;
      end else if (m_owner[i] == 0) begin
        m_ifack[i] <= 1'b0;
        m_dmack[i] <= 1'b0;
        case (pick_of(if_req && !m_ifack[i], dm_req && !m_dmack[i], m_streak[i], LIM[i]))
          2: begin
            m_owner[i] <= 2;
            m_addr[i]  <= dm_addr; m_we[i] <= dm_we; m_wd[i] <= dm_wdata;
            m_streak[i] <= !if_req ? 0 : ((m_streak[i] < LIM[i]) ? m_streak[i] + 1 : LIM[i]);
          end
          1: begin
            m_owner[i] <= 1;
            m_addr[i]  <= if_addr; m_we[i] <= 1'b0; m_wd[i] <= 0;
            m_streak[i] <= 0;
          end
          default: ;
        endcase
      end else begin
        m_ifack[i] <= (m_owner[i] == 1) && mack[i];
        m_dmack[i] <= (m_owner[i] == 2) && mack[i];
        if (mack[i]) begin
          m_owner[i] <= 0;
          if (m_owner[i] == 1) m_ifrd[i] <= mrd[i];
          else                 m_dmrd[i] <= m_we[i] ? 32'd0 : mrd[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chkb($sformatf("u%0d.mem_req", i), mem_req[i], m_owner[i] != 0);
        chkb($sformatf("u%0d.busy", i), busy[i], m_owner[i] != 0);
        chkb($sformatf("u%0d.if_ack", i), if_ack[i], m_ifack[i]);
        chkb($sformatf("u%0d.dm_ack", i), dm_ack[i], m_dmack[i]);
        chk($sformatf("u%0d.if_rdata", i), if_rdata[i], m_ifrd[i]);
        chk($sformatf("u%0d.dm_rdata", i), dm_rdata[i], m_dmrd[i]);
        if (m_owner[i] != 0) begin
          chk($sformatf("u%0d.mem_addr", i), mem_addr[i], m_addr[i]);
          chkb($sformatf("u%0d.mem_we", i), mem_we[i], m_we[i]);
          chk($sformatf("u%0d.mem_wdata", i), mem_wdata[i], m_wd[i]);
        end
      end
    end
  end

  // Grant log: 0 = data, 1 = fetch (fetch address 0x1000 during the arbitration phases).
  int   ga[$];
  int   gb[$];
  logic [1:0] req_prev = 2'b00;
  always @(negedge clk) begin
    if (mem_req[0] && !req_prev[0]) ga.push_back((mem_addr[0] == 32'h1000) ? 1 : 0);
    if (mem_req[1] && !req_prev[1]) gb.push_back((mem_addr[1] == 32'h1000) ? 1 : 0);
    req_prev <= mem_req;
  end

  task automatic chk_seq(input string name, input int which, input int exp []);
    for (int k = 0; k < exp.size(); k++) begin
      int got;
      if (which == 0) got = (k < ga.size()) ? ga[k] : 2;
      else            got = (k < gb.size()) ? gb[k] : 2;
      chk($sformatf("%s[%0d]", name, k), got, exp[k]);
    end
  endtask

  task automatic restart(input logic ireq, input logic dreq);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    ga.delete(); gb.delete();
    rst = 1'b1; if_req = ireq; dm_req = dreq;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int seq_alt [];
    int seq_b   [];
    int seq_c   [];
    seq_alt = '{0, 1, 0, 1, 0, 1};
    seq_b   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    seq_c   = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h40; dm_addr = 32'h200; dm_wdata = 32'h0;
    auto_a = 1'b0; mack_drv = 1'b0; mrd_drv = 32'h0;

    // reset held with both requests high
    repeat (3) @(negedge clk);
    chkb("rst.mem_req", mem_req[0], 1'b0);
    chkb("rst.busy", busy[0], 1'b0);
    chkb("rst.if_ack", if_ack[0], 1'b0);
    chkb("rst.dm_ack", dm_ack[0], 1'b0);
    chk("rst.mem_addr", mem_addr[0], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chkb("rel.mem_req", mem_req[0], 1'b1);
    chk("rel.mem_addr", mem_addr[0], 32'h200);
    mack_drv = 1'b1; mrd_drv = 32'h1111_2222;
    @(negedge clk);
    chkb("rel.dm_ack", dm_ack[0], 1'b1);
    chk("rel.dm_rdata", dm_rdata[0], 32'h1111_2222);
    mack_drv = 1'b0; dm_req = 1'b0;

    // single fetch, zero-wait (fetch granted in the data ack cycle)
    @(negedge clk);
    chkb("if.mem_req_t1", mem_req[0], 1'b1);
    chk("if.mem_addr", mem_addr[0], 32'h40);
    chkb("if.mem_we", mem_we[0], 1'b0);
    chk("if.mem_wdata", mem_wdata[0], 32'h0);
    mack_drv = 1'b1; mrd_drv = 32'h2008_0005;
    @(negedge clk);
    chkb("if.ack_t2", if_ack[0], 1'b1);
    chk("if.rdata_t2", if_rdata[0], 32'h2008_0005);
    chkb("if.mem_req_t2", mem_req[0], 1'b0);
    mack_drv = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chkb("if.ack_t3", if_ack[0], 1'b0);
    chk("if.rdata_hold", if_rdata[0], 32'h2008_0005);

    // data write with three wait cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; mrd_drv = 32'h5555_5555;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chkb($sformatf("wr.mem_req%0d", k), mem_req[0], 1'b1);
      chkb($sformatf("wr.mem_we%0d", k), mem_we[0], 1'b1);
      chk($sformatf("wr.mem_addr%0d", k), mem_addr[0], 32'h100);
      chk($sformatf("wr.mem_wdata%0d", k), mem_wdata[0], 32'hDEAD_BEEF);
      chkb($sformatf("wr.dm_ack%0d", k), dm_ack[0], 1'b0);
      mack_drv = (k == 3);
      @(negedge clk);
    end
    chkb("wr.dm_ack", dm_ack[0], 1'b1);
    chk("wr.dm_rdata", dm_rdata[0], 32'h0);
    mack_drv = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    chkb("wr.dm_ack_once", dm_ack[0], 1'b0);

    // stray mem_ack while idle
    mack_drv = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chkb("stray.if_ack", if_ack[0], 1'b0);
      chkb("stray.dm_ack", dm_ack[0], 1'b0);
      chkb("stray.mem_req", mem_req[0], 1'b0);
    end
    mack_drv = 1'b0;

    // fetch holds request through its ack cycle: no second grant
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    chk("hold.mem_addr", mem_addr[0], 32'h80);
    mack_drv = 1'b1; mrd_drv = 32'hCAFE_0001;
    @(negedge clk);
    chkb("hold.if_ack", if_ack[0], 1'b1);
    mack_drv = 1'b0;
    @(negedge clk);
    chkb("hold.no_regrant", mem_req[0], 1'b0);
    chkb("hold.if_ack_once", if_ack[0], 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    chkb("hold.idle", mem_req[0], 1'b0);

    // reset in the middle of a data read; the late ack must be ignored
    dm_req = 1'b1; dm_addr = 32'h300;
    @(negedge clk);
    chkb("mid.mem_req", mem_req[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chkb("mid.mem_req_rst", mem_req[0], 1'b0);
    chkb("mid.busy_rst", busy[0], 1'b0);
    chk("mid.mem_addr_rst", mem_addr[0], 32'h0);
    chk("mid.if_rdata_rst", if_rdata[0], 32'h0);
    rst = 1'b1; dm_req = 1'b0; mack_drv = 1'b1;
    @(negedge clk);
    chkb("mid.no_dm_ack", dm_ack[0], 1'b0);
    chkb("mid.idle", mem_req[0], 1'b0);
    mack_drv = 1'b0;
    @(negedge clk);
    chkb("mid.no_dm_ack2", dm_ack[0], 1'b0);
    if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    chk("mid.regrant_addr", mem_addr[0], 32'h44);
    mack_drv = 1'b1; mrd_drv = 32'h1234;
    @(negedge clk);
    chkb("mid.if_ack", if_ack[0], 1'b1);
    mack_drv = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // arbitration phases with zero-wait memory on both instances
    auto_a = 1'b1; if_addr = 32'h1000; dm_addr = 32'h2000; dm_we = 1'b0;

    restart(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk_seq("alt", 0, seq_alt);

    // fetch backs off in each data ack cycle, so data keeps winning until the streak saturates
    restart(1'b1, 1'b1);
    repeat (40) begin
      @(negedge clk);
      if_req = !dm_ack[0];
    end
    chk_seq("starve4", 0, seq_b);

    restart(1'b1, 1'b1);
    repeat (30) begin
      @(negedge clk);
      if_req = !dm_ack[1];
    end
    chk_seq("strict0", 1, seq_c);

    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
